prod_accum_stage: RTL and testbench
===================================

// Module: prod_accum_stage
// PURPOSE
//   Downstream consumer of the pipelined 18x18 signed multiplier. Accumulates a frame of
//   cfg_len consecutive 36-bit products into an ACC_W-bit sum and presents one result per frame.
//   A one-deep output register with valid/ready lets the next frame accumulate while the
//   previous result waits. The multiplier cannot stall, so this stage never backpressures
//   its input; lost results are flagged instead.
// PARAMETERS
//   PROD_W  36  product width (signed, two's complement)
//   ACC_W   48  accumulator and result width (ACC_W >= PROD_W)
//   LEN_W   8   width of cfg_len and the internal product counter
// PORTS
//   clk        in   1       clock; all state updates on posedge clk
//   rst        in   1       synchronous reset, active-high
//   prod_valid in   1       prod carries a valid product this cycle
//   prod       in   PROD_W  signed product from the multiplier
//   cfg_len    in   LEN_W   products per frame; sampled on the first product of each frame
//   out_data   out  ACC_W   signed frame sum
//   out_valid  out  1       out_data holds an unconsumed result
//   out_ready  in   1       downstream accepts out_data when out_valid && out_ready
//   busy       out  1       a frame is partially accumulated (cnt != 0)
//   overrun    out  1       sticky: a completed result was dropped
//   out_sat    out  1       result saturated (ACC_SAT_EN only; tied 0 otherwise)
// BEHAVIOUR
//   - Reset: acc=0, cnt=0, len_q=0, out_data=0, out_valid=0, busy=0, overrun=0, out_sat=0.
//     Reset during a frame discards partial sum and any held result.
//   - prod_valid=0: no state change except the output handshake.
//   - First product (cnt==0, prod_valid=1): len_q <= (cfg_len==0 ? 1 : cfg_len);
//     acc <= sext(prod). cfg_len changes mid-frame are ignored.
//   - Later products: acc <= acc + sext(prod); cnt <= cnt+1.
//   - Frame end: accepted product is number len_q (cnt == eff_len-1, eff_len from cfg_len
//     on the first cycle). Final sum = acc + sext(prod), or sext(prod) when eff_len==1.
//     cnt <= 0; acc is not reused; next valid starts a new frame.
//   - Latency: out_valid rises the cycle after the last product is accepted.
//     Back-to-back frames are legal with no gap cycles.
//   - Output register:
//       frame end and (!out_valid or out_ready)  -> load final sum; out_valid=1
//       frame end and out_valid and !out_ready   -> drop new sum; keep held value; overrun<=1
//       no frame end and out_valid and out_ready -> out_valid<=0
//     out_data is stable while out_valid && !out_ready.
//   - Arithmetic: signed; sext() sign-extends PROD_W to ACC_W. Without the macro, the sum
//     wraps modulo 2^ACC_W.
//   - overrun clears only on rst.
// CONFIGURATION
//   ACC_SAT_EN defined: each add saturates to +(2^(ACC_W-1)-1) or -2^(ACC_W-1).
//     A per-frame sticky bit records any saturation in the frame; it is loaded to out_sat
//     with the result. Saturation persists: later adds start from the clamped value.
//   ACC_SAT_EN undefined: wrap-around arithmetic; out_sat tied 0; no saturation logic.
// TESTING
//   1. cfg_len=4; products 10,-3,7,1 on consecutive cycles
//      -> out_valid one cycle after the 4th; out_data=15; busy high for cycles 1-3.
//   2. cfg_len=1, out_ready=1; products 5,6,7 back-to-back
//      -> out_data 5,6,7 on consecutive cycles; out_valid continuously high.
//   3. cfg_len=2, out_ready=0; frames (1,2) then (3,4)
//      -> out_data stays 3; overrun=1 after 2nd frame; out_ready=1 -> out_valid drops next cycle.
//   4. Frame end coinciding with out_ready=1 while a result is held
//      -> new sum replaces old in that cycle; out_valid stays 1; overrun stays 0.
//   5. rst asserted after 2 of 4 products; then cfg_len=3 with 1,1,1
//      -> all outputs 0 after reset; next result=3, no stale partial sum.
//   6. ACC_W=36; cfg_len=2; products 2^34,2^34
//      -> ACC_SAT_EN: out_data=2^35-1, out_sat=1. Without macro: out_data=-2^35.

Source files
------------

// File: rtl/prod_accum_stage_if.sv
// Bus between the multiplier-side producer and prod_accum_stage: product input, config,
// result handshake and status flags.
interface prod_accum_stage_if #(
  parameter int unsigned PROD_W = 36,
  parameter int unsigned ACC_W  = 48,
  parameter int unsigned LEN_W  = 8
) ();
  logic              prod_valid;
  logic [PROD_W-1:0] prod;
  logic [LEN_W-1:0]  cfg_len;
  logic [ACC_W-1:0]  out_data;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic              overrun;
  logic              out_sat;

  modport master (
    output prod_valid, prod, cfg_len, out_ready,
    input  out_data, out_valid, busy, overrun, out_sat
  );

  modport slave (
    input  prod_valid, prod, cfg_len, out_ready,
    output out_data, out_valid, busy, overrun, out_sat
  );
endinterface

// File: rtl/prod_accum_stage.sv
// Frame accumulator for signed products with a one-deep valid/ready result register.
// Define ACC_SAT_EN for saturating adds and the out_sat flag; otherwise sums wrap.
module prod_accum_stage #(
  parameter int unsigned PROD_W = 36,
  parameter int unsigned ACC_W  = 48,
  parameter int unsigned LEN_W  = 8
) (
  input logic               clk,
  input logic               rst,
  prod_accum_stage_if.slave acc_bus
);

  logic signed [ACC_W-1:0] r_acc;
  logic [LEN_W-1:0]        r_cnt;
  logic [LEN_W-1:0]        r_len;
  logic [ACC_W-1:0]        r_out_data;
  logic                    r_out_valid;
  logic                    r_overrun;

  logic                    w_first;
  logic [LEN_W-1:0]        w_len_cfg;
  logic [LEN_W-1:0]        w_eff_len;
  logic                    w_last;
  logic signed [PROD_W-1:0] w_prod_s;
  logic signed [ACC_W-1:0] w_prod_sext;
  logic signed [ACC_W-1:0] w_base;
  logic signed [ACC_W-1:0] w_sum;

  always_comb begin
    w_first     = (r_cnt == '0);
    w_len_cfg   = (acc_bus.cfg_len == '0) ? LEN_W'(1) : acc_bus.cfg_len;
    w_eff_len   = w_first ? w_len_cfg : r_len;
    w_last      = acc_bus.prod_valid && (r_cnt == w_eff_len - LEN_W'(1));
    w_prod_s    = acc_bus.prod;
    w_prod_sext = ACC_W'(w_prod_s);
    // A new frame starts from zero rather than reusing the previous frame's sum.
    w_base      = w_first ? '0 : r_acc;
  end

`ifdef ACC_SAT_EN
  logic signed [ACC_W:0] w_wide;
  logic                  w_ovf;
  logic                  w_frame_sat;
  logic                  r_frame_sat;
  logic                  r_out_sat;

  always_comb begin
    w_wide = {w_base[ACC_W-1], w_base} + {w_prod_sext[ACC_W-1], w_prod_sext};
    w_ovf  = w_wide[ACC_W] ^ w_wide[ACC_W-1];
    if (w_ovf) begin
      w_sum = w_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end else begin
      w_sum = w_wide[ACC_W-1:0];
    end
    w_frame_sat = (w_first ? 1'b0 : r_frame_sat) | w_ovf;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame_sat <= 1'b0;
      r_out_sat   <= 1'b0;
    end else begin
      if (acc_bus.prod_valid) r_frame_sat <= w_frame_sat;
      if (w_last && (!r_out_valid || acc_bus.out_ready)) r_out_sat <= w_frame_sat;
    end
  end

  assign acc_bus.out_sat = r_out_sat;
`else
  always_comb begin
    w_sum = w_base + w_prod_sext;
  end

  assign acc_bus.out_sat = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc       <= '0;
      r_cnt       <= '0;
      r_len       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (acc_bus.prod_valid) begin
        r_acc <= w_sum;
        r_cnt <= w_last ? '0 : r_cnt + LEN_W'(1);
        if (w_first) r_len <= w_len_cfg;
      end
      // A held result is never overwritten unless it is consumed in the same cycle.
      if (w_last && (!r_out_valid || acc_bus.out_ready)) begin
        r_out_data  <= w_sum;
        r_out_valid <= 1'b1;
      end else if (w_last) begin
        r_overrun <= 1'b1;
      end else if (r_out_valid && acc_bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign acc_bus.out_data  = r_out_data;
  assign acc_bus.out_valid = r_out_valid;
  assign acc_bus.busy      = (r_cnt != '0);
  assign acc_bus.overrun   = r_overrun;

endmodule

// File: tb/tb_prod_accum_stage.sv
// Scoreboard bench for prod_accum_stage: frame sums, handshake, overrun, reset and overflow.
module tb_prod_accum_stage;

  typedef struct {
    longint data;
    bit     sat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  prod_accum_stage_if #(.PROD_W(36), .ACC_W(48), .LEN_W(8)) bus1 ();
  prod_accum_stage_if #(.PROD_W(36), .ACC_W(36), .LEN_W(8)) bus2 ();

  prod_accum_stage #(.PROD_W(36), .ACC_W(48), .LEN_W(8)) u_dut (
    .clk     (clk),
    .rst     (rst),
    .acc_bus (bus1)
  );

  prod_accum_stage #(.PROD_W(36), .ACC_W(36), .LEN_W(8)) u_dut_narrow (
    .clk     (clk),
    .rst     (rst),
    .acc_bus (bus2)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input longint d, input bit s);
    exp_t e;
    e.data = d;
    e.sat  = s;
    sb_q.push_back(e);
  endtask

  // Compare every result the DUT hands off on the coming edge.
  always @(negedge clk) begin
    if (!rst && bus1.out_valid && bus1.out_ready) begin
      check("sb_pending", 64'(sb_q.size() != 0), 64'd1);
      if (sb_q.size() != 0) begin
        exp_t e;
        e = sb_q.pop_front();
        check("sb_data", longint'($signed(bus1.out_data)), e.data);
        check("sb_sat", 64'(bus1.out_sat), 64'(e.sat));
      end
    end
  end

  initial begin
    longint exp6;
    bit     sat6;

    bus1.prod_valid = 1'b0;
    bus1.prod       = '0;
    bus1.cfg_len    = '0;
    bus1.out_ready  = 1'b1;
    bus2.prod_valid = 1'b0;
    bus2.prod       = '0;
    bus2.cfg_len    = '0;
    bus2.out_ready  = 1'b1;
    repeat (3) cyc();
    check("rst_data", 64'(bus1.out_data), 64'd0);
    check("rst_valid", 64'(bus1.out_valid), 64'd0);
    check("rst_busy", 64'(bus1.busy), 64'd0);
    check("rst_overrun", 64'(bus1.overrun), 64'd0);
    check("rst_sat", 64'(bus1.out_sat), 64'd0);
    rst = 1'b0;
    cyc();

    // 1: four-product frame
    bus1.cfg_len = 8'd4;
    push(15, 1'b0);
    bus1.prod_valid = 1'b1;
    bus1.prod = 36'sd10;
    cyc(); check("t1_busy1", 64'(bus1.busy), 64'd1);
    bus1.prod = -36'sd3;
    cyc(); check("t1_busy2", 64'(bus1.busy), 64'd1);
    check("t1_novalid", 64'(bus1.out_valid), 64'd0);
    bus1.prod = 36'sd7;
    cyc(); check("t1_busy3", 64'(bus1.busy), 64'd1);
    bus1.prod = 36'sd1;
    cyc(); check("t1_valid", 64'(bus1.out_valid), 64'd1);
    check("t1_busy_end", 64'(bus1.busy), 64'd0);
    bus1.prod_valid = 1'b0;
    cyc(); check("t1_drop", 64'(bus1.out_valid), 64'd0);

    // 2: single-product frames back-to-back
    bus1.cfg_len = 8'd1;
    push(5, 1'b0); push(6, 1'b0); push(7, 1'b0);
    bus1.prod_valid = 1'b1;
    bus1.prod = 36'sd5;
    cyc(); check("t2_v1", 64'(bus1.out_valid), 64'd1);
    bus1.prod = 36'sd6;
    cyc(); check("t2_v2", 64'(bus1.out_valid), 64'd1);
    bus1.prod = 36'sd7;
    cyc(); check("t2_v3", 64'(bus1.out_valid), 64'd1);
    bus1.prod_valid = 1'b0;
    cyc(); check("t2_drop", 64'(bus1.out_valid), 64'd0);

    // 3: stalled output, second frame is lost
    bus1.cfg_len = 8'd2;
    bus1.out_ready = 1'b0;
    push(3, 1'b0);
    bus1.prod_valid = 1'b1;
    bus1.prod = 36'sd1; cyc();
    bus1.prod = 36'sd2; cyc();
    check("t3_ovr_before", 64'(bus1.overrun), 64'd0);
    bus1.prod = 36'sd3; cyc();
    bus1.prod = 36'sd4; cyc();
    bus1.prod_valid = 1'b0;
    check("t3_held", 64'(bus1.out_data), 64'd3);
    check("t3_valid", 64'(bus1.out_valid), 64'd1);
    check("t3_overrun", 64'(bus1.overrun), 64'd1);
    cyc();
    check("t3_ovr_sticky", 64'(bus1.overrun), 64'd1);
    bus1.out_ready = 1'b1;
    cyc(); check("t3_drop", 64'(bus1.out_valid), 64'd0);

    // 4: frame end replaces a result consumed in the same cycle
    rst = 1'b1; cyc(); rst = 1'b0;
    bus1.cfg_len = 8'd1;
    bus1.out_ready = 1'b0;
    push(8, 1'b0);
    bus1.prod_valid = 1'b1;
    bus1.prod = 36'sd8; cyc();
    bus1.prod_valid = 1'b0; cyc();
    push(9, 1'b0);
    bus1.out_ready = 1'b1;
    bus1.prod_valid = 1'b1;
    bus1.prod = 36'sd9; cyc();
    bus1.prod_valid = 1'b0;
    check("t4_valid", 64'(bus1.out_valid), 64'd1);
    check("t4_data", 64'(bus1.out_data), 64'd9);
    check("t4_no_ovr", 64'(bus1.overrun), 64'd0);
    cyc(); check("t4_drop", 64'(bus1.out_valid), 64'd0);

    // 5: reset mid-frame discards partial sum
    bus1.cfg_len = 8'd4;
    bus1.prod_valid = 1'b1;
    bus1.prod = 36'sd5; cyc();
    bus1.prod = 36'sd6; cyc();
    bus1.prod_valid = 1'b0;
    rst = 1'b1; cyc();
    check("t5_data", 64'(bus1.out_data), 64'd0);
    check("t5_valid", 64'(bus1.out_valid), 64'd0);
    check("t5_busy", 64'(bus1.busy), 64'd0);
    check("t5_overrun", 64'(bus1.overrun), 64'd0);
    rst = 1'b0;
    bus1.cfg_len = 8'd3;
    push(3, 1'b0);
    bus1.prod_valid = 1'b1;
    bus1.prod = 36'sd1;
    repeat (3) cyc();
    bus1.prod_valid = 1'b0;
    check("t5_valid_new", 64'(bus1.out_valid), 64'd1);
    cyc();

    // 6: overflow in a 36-bit accumulator
`ifdef ACC_SAT_EN
    exp6 = (64'sd1 <<< 35) - 64'sd1;
    sat6 = 1'b1;
`else
    exp6 = -(64'sd1 <<< 35);
    sat6 = 1'b0;
`endif
    bus2.cfg_len = 8'd2;
    bus2.prod_valid = 1'b1;
    bus2.prod = 36'h4_0000_0000; cyc();
    bus2.prod = 36'h4_0000_0000; cyc();
    bus2.prod_valid = 1'b0;
    check("t6_valid", 64'(bus2.out_valid), 64'd1);
    check("t6_data", longint'($signed(bus2.out_data)), exp6);
    check("t6_sat", 64'(bus2.out_sat), 64'(sat6));
    cyc();

    check("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
